// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl
//   Single-clock FIFO that buffers ADC samples between acquisition and readout.
//   It has dual-port storage, wrapping read/write pointers and a separate
//   registered fill-level counter. Read data is registered. It also provides
//   full/empty flags, programmable almost-full/almost-empty flags, sticky
//   overflow/underflow flags and a synchronous flush.
// Ports
//   clk_i, rst_n_i        clock (rising edge), async active-low reset
//   flush_i               sync clear of pointers, level, sticky flags, rd_valid_o
//   wr_en_i, wr_data_i    write request / data
//   rd_en_i               read request
//   rd_data_o             registered read data, holds when no read is accepted
//   rd_valid_o            1-cycle pulse: rd_data_o updated by the previous read
//   full_o, empty_o       level_o == DEPTH / level_o == 0
//   almost_full_o         level_o >= AFULL_LEVEL
//   almost_empty_o        level_o <= AEMPTY_LEVEL
//   level_o               stored word count, 0..DEPTH
//   overflow_o            sticky: write attempted while full
//   underflow_o           sticky: read attempted while empty
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH   = 12,
  parameter int ADDR_WIDTH   = 8,
  parameter int AFULL_LEVEL  = 240,
  parameter int AEMPTY_LEVEL = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [ADDR_WIDTH:0]   level_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LVL_FULL   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LVL_AFULL  = (ADDR_WIDTH+1)'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] LVL_AEMPTY = (ADDR_WIDTH+1)'(AEMPTY_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                  wr_acc, rd_acc;

  // Acceptance uses the flags registered before the edge. Because of that, a
  // write into an empty FIFO is not bypassed to the read side in the same cycle.
  // Flush overrides both requests.
  assign wr_acc = wr_en_i && !full_o  && !flush_i;
  assign rd_acc = rd_en_i && !empty_o && !flush_i;

  // Storage is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem[wr_ptr] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_o     <= '0;
      rd_data_o   <= '0;
      rd_valid_o  <= 1'b0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else if (flush_i) begin
      // rd_data_o keeps its last value across a flush.
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_o     <= '0;
      rd_valid_o  <= 1'b0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      rd_valid_o <= rd_acc;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr    <= rd_ptr + 1'b1;
        rd_data_o <= mem[rd_ptr];
      end
      case ({wr_acc, rd_acc})
        2'b10:   level_o <= level_o + 1'b1;
        2'b01:   level_o <= level_o - 1'b1;
        default: level_o <= level_o;
      endcase
      if (wr_en_i && full_o)  overflow_o  <= 1'b1;
      if (rd_en_i && empty_o) underflow_o <= 1'b1;
    end
  end

  // Flags are decoded only from the registered level, so inputs cannot make them glitch.
  assign full_o         = (level_o == LVL_FULL);
  assign empty_o        = (level_o == '0);
  assign almost_full_o  = (level_o >= LVL_AFULL);
  assign almost_empty_o = (level_o <= LVL_AEMPTY);

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
module tb_sync_fifo_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_n_i, flush_i, wr_en_i, rd_en_i;
  logic [11:0] wr_data_i, rd_data_o;
  logic        rd_valid_o, full_o, empty_o, almost_full_o, almost_empty_o;
  logic [8:0]  level_o;
  logic        overflow_o, underflow_o;

  sync_fifo_ctrl #(.DATA_WIDTH(12), .ADDR_WIDTH(8), .AFULL_LEVEL(240), .AEMPTY_LEVEL(16)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i), .wr_en_i(wr_en_i),
    .wr_data_i(wr_data_i), .rd_en_i(rd_en_i), .rd_data_o(rd_data_o),
    .rd_valid_o(rd_valid_o), .full_o(full_o), .empty_o(empty_o),
    .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o),
    .level_o(level_o), .overflow_o(overflow_o), .underflow_o(underflow_o));

  always #5 clk_i = ~clk_i;

  int          errors = 0, checks = 0;
  logic [11:0] mq[$];      // model FIFO contents
  logic [11:0] exp_q[$];   // scoreboard: expected read data, pushed on drive
  logic        m_ovf = 1'b0, m_unf = 1'b0;
  logic [11:0] last_data = '0;
  logic [11:0] wd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state();
    int n;
    n = mq.size();
    chk("level",  32'(level_o), 32'(n));
    chk("full",   32'(full_o), 32'(n == 256));
    chk("empty",  32'(empty_o), 32'(n == 0));
    chk("afull",  32'(almost_full_o), 32'(n >= 240));
    chk("aempty", 32'(almost_empty_o), 32'(n <= 16));
    chk("ovf",    32'(overflow_o), 32'(m_ovf));
    chk("unf",    32'(underflow_o), 32'(m_unf));
  endtask

  // One clock cycle of stimulus. The model decides acceptance from the
  // pre-edge level. Expected read data goes into exp_q and is popped
  // when rd_valid_o shows up.
  task automatic step(input logic wr, input logic [11:0] d, input logic rd, input logic fl);
    logic exp_vld, full_m, empty_m;
    wr_en_i = wr; wr_data_i = d; rd_en_i = rd; flush_i = fl;
    exp_vld = 1'b0;
    full_m  = (mq.size() == 256);
    empty_m = (mq.size() == 0);
    if (fl) begin
      mq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      if (rd && !empty_m) begin exp_q.push_back(mq.pop_front()); exp_vld = 1'b1; end
      if (rd && empty_m)  m_unf = 1'b1;
      if (wr && !full_m)  mq.push_back(d);
      if (wr && full_m)   m_ovf = 1'b1;
    end
    @(posedge clk_i); #1;
    chk("rd_valid", 32'(rd_valid_o), 32'(exp_vld));
    if (exp_vld) begin
      if (exp_q.size() == 0) chk("scoreboard_empty", 32'd1, 32'd0);
      else last_data = exp_q.pop_front();
    end
    chk("rd_data", 32'(rd_data_o), 32'(last_data));
    chk_state();
    wr_en_i = 1'b0; rd_en_i = 1'b0; flush_i = 1'b0;
  endtask

  initial begin
    rst_n_i = 1'b0; flush_i = 1'b0; wr_en_i = 1'b0; rd_en_i = 1'b0; wr_data_i = '0;
    repeat (2) @(posedge clk_i);
    #1 chk_state();
    chk("rst_rd_data", 32'(rd_data_o), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid_o), 32'd0);
    rst_n_i = 1'b1;

    // Async reset asserted mid-cycle while data is buffered.
    step(1, 12'h0AA, 0, 0); step(1, 12'h0BB, 0, 0); step(0, 0, 1, 0);
    @(posedge clk_i); #2;
    rst_n_i = 1'b0;
    #1;
    mq.delete(); exp_q.delete(); m_ovf = 1'b0; m_unf = 1'b0; last_data = '0;
    chk("async_rst_rd_data", 32'(rd_data_o), 32'd0);
    chk("async_rst_rd_valid", 32'(rd_valid_o), 32'd0);
    chk_state();
    @(posedge clk_i); #1 rst_n_i = 1'b1;

    // Fill to full, then attempt one more write.
    for (int i = 1; i <= 256; i++) step(1, 12'(i), 0, 0);
    step(1, 12'h3FF, 0, 0);
    chk("ovf_after_257", 32'(overflow_o), 32'd1);

    // Drain everything in order, then attempt one more read.
    for (int i = 0; i < 256; i++) step(0, 0, 1, 0);
    chk("last_word", 32'(rd_data_o), 32'h100);
    step(0, 0, 1, 0);
    chk("unf_extra_read", 32'(underflow_o), 32'd1);

    // Flush clears sticky flags, then run simultaneous read and write across two pointer wraps.
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin wd++; step(1, wd, 0, 0); end
    for (int i = 0; i < 600; i++) begin wd++; step(1, wd, 1, 0); end
    chk("stream_level", 32'(level_o), 32'd5);

    // Fill to full, overflow, then read and write together while full.
    while (mq.size() < 256) begin wd++; step(1, wd, 0, 0); end
    wd++; step(1, wd, 0, 0);
    wd++; step(1, wd, 1, 0);
    chk("full_rw_level", 32'(level_o), 32'd255);

    // Drain to 10 with overflow still set, then flush together with a write.
    while (mq.size() > 10) step(0, 0, 1, 0);
    chk("ovf_at_10", 32'(overflow_o), 32'd1);
    step(1, 12'h555, 0, 1);
    chk("flush_level", 32'(level_o), 32'd0);
    step(1, 12'h123, 0, 0);
    step(0, 0, 1, 0);
    chk("post_flush_word", 32'(rd_data_o), 32'h123);

    // Read and write together while empty: the write lands, the read underflows.
    step(1, 12'h777, 1, 0);
    chk("empty_rw_level", 32'(level_o), 32'd1);
    step(0, 0, 1, 0);
    chk("empty_rw_word", 32'(rd_data_o), 32'h777);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
